// File: rtl/move_scheduler_if.sv
// Move command handshake between the SPI message handler (master) and the scheduler (slave).
interface move_scheduler_if #(
  parameter int MOVE_W = 64
);
  logic              move_valid;
  logic              move_ready;
  logic              move_dir;
  logic [MOVE_W-1:0] move_duration;
  logic [MOVE_W-1:0] move_increment;
  logic [MOVE_W-1:0] move_incinc;

  modport master (
    output move_valid, move_dir, move_duration, move_increment, move_incinc,
    input  move_ready
  );

  modport slave (
    input  move_valid, move_dir, move_duration, move_increment, move_incinc,
    output move_ready
  );
endinterface

// File: rtl/move_scheduler.sv
// Move FIFO plus IDLE/LOAD/RUN sequencer that paces the stepper accumulator with load and tick strobes.
module move_scheduler #(
  parameter int DEPTH  = 4,
  parameter int MOVE_W = 64,
  parameter int DIV_W  = 24,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic              enable,
  input  logic              abort,
  input  logic [DIV_W-1:0]  clock_divisor,
  move_scheduler_if.slave   cmd,
  output logic              step_dir,
  output logic [MOVE_W-1:0] step_increment,
  output logic [MOVE_W-1:0] step_incinc,
  output logic              load,
  output logic              tick,
  output logic              active,
  output logic              move_done,
  output logic              aborted,
  output logic [CNT_W-1:0]  queue_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 1 + 3 * MOVE_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [1:0]        state;
  logic [ENT_W-1:0]  fifo_mem [DEPTH];
  logic [ENT_W-1:0]  head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [MOVE_W-1:0] dur_r;
  logic [MOVE_W-1:0] tick_cnt;
  logic [DIV_W-1:0]  div_r;
  logic [DIV_W-1:0]  presc;
  logic              done_r;
  logic              aborted_r;
  logic              push;
  logic              pop;
  logic              tick_w;
  logic              finishing;

  assign cmd.move_ready = (count != CNT_W'(DEPTH));
  assign push           = cmd.move_valid && cmd.move_ready && !abort;
  assign head           = fifo_mem[rd_ptr];

  assign tick_w    = (state == RUN) && (presc == div_r - DIV_W'(1));
  assign finishing = ((state == LOAD) && (dur_r == '0)) ||
                     (tick_w && (tick_cnt == dur_r - MOVE_W'(1)));
  // A new move may start from IDLE or in the same cycle the current one finishes.
  assign pop       = !abort && enable && (count != '0) && ((state == IDLE) || finishing);

  assign queue_count = count;
  assign load        = (state == LOAD);
  assign tick        = tick_w;
  assign active      = (state != IDLE);
  assign move_done   = done_r;
  assign aborted     = aborted_r;

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd.move_dir, cmd.move_duration, cmd.move_increment, cmd.move_incinc};
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Divisor is captured during LOAD, so the first tick lands div cycles after the load strobe.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      step_dir       <= 1'b0;
      step_increment <= '0;
      step_incinc    <= '0;
      dur_r          <= '0;
      tick_cnt       <= '0;
      div_r          <= DIV_W'(1);
      presc          <= '0;
      done_r         <= 1'b0;
      aborted_r      <= 1'b0;
    end else begin
      done_r    <= finishing && !abort;
      aborted_r <= abort;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (pop) state <= LOAD;
          end
          LOAD: begin
            div_r    <= (clock_divisor == '0) ? DIV_W'(1) : clock_divisor;
            presc    <= '0;
            tick_cnt <= '0;
            if (dur_r == '0) state <= pop ? LOAD : IDLE;
            else             state <= RUN;
          end
          RUN: begin
            if (tick_w) begin
              presc    <= '0;
              tick_cnt <= tick_cnt + MOVE_W'(1);
              if (finishing) state <= pop ? LOAD : IDLE;
            end else begin
              presc <= presc + DIV_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
        if (pop) begin
          {step_dir, dur_r, step_increment, step_incinc} <= head;
        end
      end
    end
  end

endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
Buffers coordinated-move commands from the SPI message handler and sequences them onto the stepper timing datapath, one move at a time. Owns the clock-divisor tick prescaler and the per-move tick counter. Presents each move's parameters together with a load strobe, then a tick strobe that paces the accumulator datapath. Moves issue back-to-back without host intervention, replacing the single-move toggle latch.

Parameters:
DEPTH, 4, move FIFO entries (power of two, >=2)
MOVE_W, 64, width of duration, increment, increment-increment
DIV_W, 24, width of clock divisor
CNT_W, $clog2(DEPTH+1), width of queue_count

Ports:
CLK  in  1  system clock (16 MHz)
resetn  in  1  asynchronous active-low reset
enable  in  1  when 0, no new move is started; a running move completes
abort  in  1  synchronous; flush FIFO and stop immediately
clock_divisor  in  DIV_W  CLK cycles per tick; sampled at LOAD
move_valid  in  1  command present
move_ready  out  1  FIFO can accept (= not full)
move_dir  in  1  direction of command
move_duration  in  MOVE_W  tick count of command
move_increment  in  MOVE_W  signed initial increment
move_incinc  in  MOVE_W  signed increment-increment
step_dir  out  1  direction of active move
step_increment  out  MOVE_W  increment of active move
step_incinc  out  MOVE_W  increment-increment of active move
load  out  1  1-cycle pulse: datapath reloads increment_r, substeps untouched
tick  out  1  1-cycle pulse: datapath performs one accumulate
active  out  1  high in LOAD and RUN
move_done  out  1  1-cycle pulse after last tick of a move
aborted  out  1  1-cycle pulse acknowledging abort
queue_count  out  CNT_W  entries held in FIFO

Behaviour:
- Reset (resetn=0, async): FIFO empty, state IDLE; all outputs 0 except move_ready=1; step_* registers 0.
- Push: accepted on rising CLK when move_valid & move_ready. move_ready = (queue_count != DEPTH); a push while full is not accepted even if a pop occurs in the same cycle.
- FIFO: circular, pointers wrap modulo DEPTH. Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged.
- States: IDLE, LOAD, RUN.
- IDLE -> LOAD when enable=1 and queue_count != 0.
- LOAD (exactly 1 cycle):
  - Head popped into step_dir/step_increment/step_incinc.
  - Latch div = max(clock_divisor, 1); duration latched.
  - Prescaler and tick counter cleared.
  - load=1 during this cycle, with step_* already showing the new values (registered on entry).
  - Next state RUN, or completion if duration == 0.
- RUN:
  - Prescaler increments each cycle; on reaching div-1 it asserts tick for one cycle, clears, and increments the tick counter.
  - First tick comes div cycles after LOAD; ticks are spaced exactly div cycles apart.
- Completion:
  - On the cycle the tick counter reaches duration, move_done pulses in the following cycle.
  - If enable and FIFO is non-empty, go to LOAD (one-cycle gap, no tick lost).
  - Otherwise go to IDLE.
  - step_* hold their last values in IDLE.
- Enable dropped during RUN: the move finishes; the scheduler then idles with the FIFO retained.
- Abort (any state):
  - Next cycle: FIFO flushed (count 0), state IDLE, tick/load suppressed from that cycle, aborted=1 for one cycle.
  - A push coinciding with abort is dropped.
  - Abort has priority over completion and LOAD in the same cycle.
- Arithmetic:
  - Tick counter is MOVE_W bits unsigned; duration is treated as unsigned.
  - Prescaler is DIV_W bits.
  - Scheduler performs no increment arithmetic; it only relays parameters.
- Reset mid-move: immediate return to the reset state; no move_done is generated.

Test Plan:
- Push 1 move (dur=3, div=4, inc=100, incinc=10, dir=1) -> load at cycle L; tick at L+4, L+8, L+12; move_done at L+13; active low afterwards; step_increment=100.
- Push 3 moves while idle, enable=1 -> three loads each exactly 1 cycle after the prior move's last tick; queue_count steps 3->2->1->0.
- Fill FIFO with DEPTH=4 entries, enable=0 -> move_ready=0, 5th move_valid is not accepted; set enable=1 -> entries drain in FIFO order.
- clock_divisor=0, dur=5 -> tick every cycle for 5 consecutive cycles; duration=0 move -> single load, move_done next cycle, zero ticks.
- Abort during RUN with 2 queued, plus a simultaneous push -> aborted pulse, queue_count=0, no further tick/load, pushed move is absent.
- Assert resetn=0 mid-RUN -> outputs 0 asynchronously, move_ready=1 and no move_done after release.
